// File: rtl/rad_sync_fifo_pkg.sv
// Shared types, constants and helpers for the single-clock show-ahead FIFO.
// Build option: define RAD_SYNC_FIFO_PARITY_EN to store and check one
// even-parity bit per entry.
package rad_sync_fifo_pkg;

  // Pointer width for the default ADDRSIZE of 3 (wrap bit + 3 address bits).
  localparam int unsigned ADDRSIZE_DFLT = 3;
  typedef logic [ADDRSIZE_DFLT:0] ptr_dflt_t;

`ifdef RAD_SYNC_FIFO_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  // Widest data word the parity helper accepts.
  localparam int unsigned PAR_MAX_W = 64;

  // Number of storage entries for a given address width.
  function automatic int unsigned depth_of(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  // Bit that makes the XOR of data and parity zero.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rad_sync_fifo_if.sv
// Producer/consumer bundle of the sync FIFO.
//   wdata/wvalid/wready : write handshake
//   rdata/rvalid/rready : show-ahead read handshake
//   count/afull/aempty  : occupancy status
//   parity_err          : sticky storage parity error (0 when parity is not built)
// master = the side that uses the FIFO, slave = the FIFO itself.
interface rad_sync_fifo_if #(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned ADDRSIZE = 3
);

  logic [DSIZE-1:0]  wdata;
  logic              wvalid;
  logic              wready;
  logic [DSIZE-1:0]  rdata;
  logic              rvalid;
  logic              rready;
  logic [ADDRSIZE:0] count;
  logic              afull;
  logic              aempty;
  logic              parity_err;

  modport master (
    output wdata, wvalid, rready,
    input  wready, rdata, rvalid, count, afull, aempty, parity_err
  );

  modport slave (
    input  wdata, wvalid, rready,
    output wready, rdata, rvalid, count, afull, aempty, parity_err
  );

endinterface

// File: rtl/rad_sync_fifo_mem.sv
// Flop-array storage for the sync FIFO: synchronous write, combinational read.
//   clk       : clock
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write word (data plus optional parity bit)
//   i_raddr   : read address
//   o_rdata_c : word at i_raddr, combinational
module rad_sync_fifo_mem
  import rad_sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDRSIZE = 3
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDRSIZE-1:0] i_waddr,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic [ADDRSIZE-1:0] i_raddr,
  output logic [WIDTH-1:0]    o_rdata_c
);

  localparam int unsigned DEPTH = depth_of(ADDRSIZE);

  // Storage is intentionally not reset; entries are only meaningful once written.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/rad_sync_fifo.sv
// Single-clock parametrised FIFO with show-ahead read, occupancy count,
// registered almost-full/almost-empty flags and optional per-entry parity.
// Build option: RAD_SYNC_FIFO_PARITY_EN adds an even-parity bit per entry and
// a sticky parity_err; without it parity_err is tied low.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset (clears pointers, count and flags)
//   bus : rad_sync_fifo_if.slave -- write/read handshakes and status outputs
module rad_sync_fifo
  import rad_sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE         = 8,
  parameter int unsigned ADDRSIZE      = 3,
  parameter int unsigned AFULL_THRESH  = 6,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic           clk,
  input  logic           rst,
  rad_sync_fifo_if.slave bus
);

  localparam int unsigned DEPTH = depth_of(ADDRSIZE);
  localparam int unsigned CW    = ADDRSIZE + 1;
  localparam int unsigned MW    = DSIZE + PAR_W;

  typedef logic [ADDRSIZE:0] ptr_t;

  localparam logic [ADDRSIZE:0] AFULL_T  = CW'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AEMPTY_T = CW'(AEMPTY_THRESH);

  // Parameter legality, reported at elaboration.
  if (ADDRSIZE < 1) begin : g_chk_addrsize
    $error("rad_sync_fifo: ADDRSIZE must be >= 1 (got %0d)", ADDRSIZE);
  end
  if (DSIZE < 1) begin : g_chk_dsize
    $error("rad_sync_fifo: DSIZE must be >= 1 (got %0d)", DSIZE);
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
    $error("rad_sync_fifo: AFULL_THRESH must be in 1..%0d (got %0d)", DEPTH, AFULL_THRESH);
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
    $error("rad_sync_fifo: AEMPTY_THRESH must be in 0..%0d (got %0d)", DEPTH - 1, AEMPTY_THRESH);
  end
`ifdef RAD_SYNC_FIFO_PARITY_EN
  if (DSIZE > PAR_MAX_W) begin : g_chk_par_w
    $error("rad_sync_fifo: parity build supports DSIZE <= %0d (got %0d)", PAR_MAX_W, DSIZE);
  end
`endif

  ptr_t              r_wptr;
  ptr_t              r_rptr;
  logic [ADDRSIZE:0] r_count;
  logic              r_wready;
  logic              r_rvalid;
  logic              r_afull;
  logic              r_aempty;

  ptr_t              w_wptr_next;
  ptr_t              w_rptr_next;
  logic [ADDRSIZE:0] w_count_next;
  logic              w_full_next;
  logic              w_empty_next;
  logic              w_push;
  logic              w_pop;
  logic [MW-1:0]     w_wentry;
  logic [MW-1:0]     w_rentry;

  // Handshakes qualify on the registered space/data-available flags, so a
  // full FIFO cannot accept and an empty one cannot pop (no bypass paths).
  assign w_push = bus.wvalid && r_wready;
  assign w_pop  = r_rvalid && bus.rready;

  // Next pointers and occupancy.
  always_comb begin
    w_wptr_next  = r_wptr;
    w_rptr_next  = r_rptr;
    w_count_next = r_count;
    if (w_push) begin
      w_wptr_next = r_wptr + ptr_t'(1);
    end
    if (w_pop) begin
      w_rptr_next = r_rptr + ptr_t'(1);
    end
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Full when the wrap bits differ but the address bits match; empty when equal.
  assign w_full_next  = (w_wptr_next[ADDRSIZE] != w_rptr_next[ADDRSIZE]) &&
                        (w_wptr_next[ADDRSIZE-1:0] == w_rptr_next[ADDRSIZE-1:0]);
  assign w_empty_next = (w_wptr_next == w_rptr_next);

  // Pointer, count and flag registers; flags come from next-state values so
  // they line up with count in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wready <= 1'b1;
      r_rvalid <= 1'b0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_wptr   <= w_wptr_next;
      r_rptr   <= w_rptr_next;
      r_count  <= w_count_next;
      r_wready <= !w_full_next;
      r_rvalid <= !w_empty_next;
      r_afull  <= (w_count_next >= AFULL_T);
      r_aempty <= (w_count_next <= AEMPTY_T);
    end
  end

  rad_sync_fifo_mem #(
    .WIDTH    (MW),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_push),
    .i_waddr   (r_wptr[ADDRSIZE-1:0]),
    .i_wdata   (w_wentry),
    .i_raddr   (r_rptr[ADDRSIZE-1:0]),
    .o_rdata_c (w_rentry)
  );

`ifdef RAD_SYNC_FIFO_PARITY_EN
  logic r_parity_err;
  logic w_par_bad;

  // Parity bit sits above the data; a good entry XORs to zero.
  assign w_wentry  = {even_parity(PAR_MAX_W'(bus.wdata)), bus.wdata};
  assign w_par_bad = w_pop && (^w_rentry);

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_par_bad) begin
      r_parity_err <= 1'b1;
    end
  end

  assign bus.parity_err = r_parity_err;
`else
  assign w_wentry       = bus.wdata;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rdata  = w_rentry[DSIZE-1:0];
  assign bus.wready = r_wready;
  assign bus.rvalid = r_rvalid;
  assign bus.count  = r_count;
  assign bus.afull  = r_afull;
  assign bus.aempty = r_aempty;

endmodule

// File: tb/tb_rad_sync_fifo.sv
// Directed, scoreboard-checked bench for rad_sync_fifo (DSIZE=8, ADDRSIZE=3,
// AFULL_THRESH=6, AEMPTY_THRESH=1). The parity step runs only when
// RAD_SYNC_FIFO_PARITY_EN is defined.
module tb_rad_sync_fifo;

  localparam int unsigned DSIZE    = 8;
  localparam int unsigned ADDRSIZE = 3;
  localparam int          DEPTH    = 8;
  localparam int          AFULL_TH = 6;
  localparam int          AEMPT_TH = 1;

  logic clk;
  logic rst;

  rad_sync_fifo_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) bus ();

  rad_sync_fifo #(
    .DSIZE         (DSIZE),
    .ADDRSIZE      (ADDRSIZE),
    .AFULL_THRESH  (AFULL_TH),
    .AEMPTY_THRESH (AEMPT_TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected queue contents and occupancy.
  logic [7:0] sb [$];
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    chk("count",  32'(bus.count),  32'(m_cnt));
    chk("wready", 32'(bus.wready), 32'(m_cnt < DEPTH));
    chk("rvalid", 32'(bus.rvalid), 32'(m_cnt > 0));
    chk("afull",  32'(bus.afull),  32'(m_cnt >= AFULL_TH));
    chk("aempty", 32'(bus.aempty), 32'(m_cnt <= AEMPT_TH));
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr);
    logic m_push;
    logic m_pop;
    bus.wvalid = wv;
    bus.wdata  = wd;
    bus.rready = rr;
    m_push = wv && (m_cnt < DEPTH);
    m_pop  = rr && (m_cnt > 0);
    if (m_pop) begin
      chk("rdata", 32'(bus.rdata), 32'(sb[0]));
      sb.delete(0);
    end
    if (m_push) sb.push_back(wd);
    @(posedge clk);
    #1;
    m_cnt = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    bus.wvalid = 1'b0;
    bus.rready = 1'b0;
    check_status();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wvalid = 1'b0;
    bus.rready = 1'b0;
    sb.delete();
    m_cnt = 0;
    check_status();
    chk("parity_err_rst", 32'(bus.parity_err), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.wvalid = 1'b0;
    bus.wdata  = '0;
    bus.rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    do_reset();

    // Fill 0x01..0x08 back-to-back, then one push at full that must be dropped.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);

    // Drain in order; then a pop request while empty must do nothing.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Hold count=3 with simultaneous push+pop across pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // At full, push+pop together pops only; 0xBB is lost.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);

    // Reset with five entries held and a push/pop pending in the reset cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    bus.wvalid = 1'b1;
    bus.wdata  = 8'hCC;
    bus.rready = 1'b1;
    do_reset();
    // FIFO must be usable straight after reset.
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);

`ifdef RAD_SYNC_FIFO_PARITY_EN
    // Corrupt the head entry (slot 0 after reset) and pop it.
    do_reset();
    step(1'b1, 8'h5A, 1'b0);
    dut.u_mem.r_mem[0][0] = ~dut.u_mem.r_mem[0][0];
    chk("parity_err_pre", 32'(bus.parity_err), 32'd0);
    bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
    sb.delete();
    m_cnt = 0;
    chk("parity_err_set", 32'(bus.parity_err), 32'd1);
    step(1'b1, 8'h33, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("parity_err_sticky", 32'(bus.parity_err), 32'd1);
    do_reset();
`else
    chk("parity_err_off", 32'(bus.parity_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
